// File: rtl/lc3_mem_responder_pkg.sv
// Shared types for the LC3 memory responder.
// Channel FSM states, request bundle and default base address.
package lc3_mem_pkg;

    localparam int LC3_ADDR_W = 16;
    localparam int LC3_DATA_W = 16;
    localparam int LC3_LAT_W  = 4;

    localparam logic [15:0] LC3_BASE_ADDR = 16'h3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic                  we;
        logic [LC3_ADDR_W-1:0] addr;
        logic [LC3_DATA_W-1:0] wdata;
        logic [LC3_LAT_W-1:0]  lat;
    } req_t;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// Request/response bus of the LC3 memory responder.
// Packed per-channel fields, channel 0 in the LSBs.
interface lc3_mem_responder_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LAT_W  = 4
);
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH*LAT_W-1:0]  ch_lat;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic [NUM_CH-1:0]        ch_complete;
    logic [NUM_CH-1:0]        busy;
    logic                     init_we;
    logic [ADDR_W-1:0]        init_addr;
    logic [DATA_W-1:0]        init_data;

    modport master (
        output ch_en, ch_we, ch_addr, ch_wdata, ch_lat,
        output init_we, init_addr, init_data,
        input  ch_rdata, ch_complete, busy
    );

    modport slave (
        input  ch_en, ch_we, ch_addr, ch_wdata, ch_lat,
        input  init_we, init_addr, init_data,
        output ch_rdata, ch_complete, busy
    );
endinterface

// File: rtl/lc3_mem_responder_chan.sv
// One responder channel: IDLE/WAIT/HOLD FSM with wait-state counter.
// The captured lat field doubles as the countdown register.
module lc3_mem_chan
    import lc3_mem_pkg::*;
#(
    parameter int  ADDR_W = 16,
    parameter int  DATA_W = 16,
    parameter int  LAT_W  = 4,
    parameter type req_t  = lc3_mem_pkg::req_t
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  req_t              req,
    input  logic              grant,
    output logic              wreq,
    output logic              complete,
    output logic              busy,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_wdata
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0] state;
    req_t       cap;
    logic       idle;
    logic       act;
    logic       cur_we;

    // Zero-wait requests are served straight from the live inputs
    always_comb begin
        idle      = (state == S_IDLE);
        act       = reset && en &&
                    ((idle && req.lat == '0) || state == S_HOLD);
        cur_we    = idle ? req.we    : cap.we;
        cur_addr  = idle ? req.addr  : cap.addr;
        cur_wdata = idle ? req.wdata : cap.wdata;
        wreq      = act && cur_we;
        complete  = act && (!cur_we || grant);
        busy      = !idle;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cap   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (en && req.lat != '0) begin
                        cap     <= req;
                        cap.lat <= req.lat - LAT_W'(1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!en) begin
                        cap.lat <= '0;
                        state   <= S_IDLE;
                    end else if (cap.lat == '0) begin
                        state   <= S_HOLD;
                    end else begin
                        cap.lat <= cap.lat - LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (!en || complete) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Multi-channel LC3 memory responder over one shared backing array.
// Reads are multi-ported; one write port arbitrated init first, then low channel.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int              NUM_CH     = 2,
    parameter int              ADDR_W     = 16,
    parameter int              DATA_W     = 16,
    parameter int              DEPTH_LOG2 = 12,
    parameter int              LAT_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(LC3_BASE_ADDR)
) (
    input  logic                clock,
    input  logic                reset,
    lc3_mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LAT_W-1:0]  lat;
    } chan_req_t;

    logic [DATA_W-1:0]        mem [DEPTH];
    chan_req_t                live [NUM_CH];
    logic [ADDR_W-1:0]        cur_addr [NUM_CH];
    logic [DATA_W-1:0]        cur_wdata [NUM_CH];
    logic [NUM_CH-1:0]        wreq;
    logic [NUM_CH-1:0]        grant;
    logic [NUM_CH-1:0]        complete;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH*DATA_W-1:0] rdata;
    logic                     wen;
    logic                     taken;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;

    function automatic logic [DEPTH_LOG2-1:0] to_idx(
        input logic [ADDR_W-1:0] a
    );
        return DEPTH_LOG2'(a - BASE_ADDR);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            live[i].we    = bus.ch_we[i];
            live[i].addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
            live[i].wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
            live[i].lat   = bus.ch_lat[i*LAT_W +: LAT_W];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        lc3_mem_chan #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .LAT_W  (LAT_W),
            .req_t  (chan_req_t)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .en        (bus.ch_en[g]),
            .req       (live[g]),
            .grant     (grant[g]),
            .wreq      (wreq[g]),
            .complete  (complete[g]),
            .busy      (busy[g]),
            .cur_addr  (cur_addr[g]),
            .cur_wdata (cur_wdata[g])
        );
    end

    // Backdoor preload always wins; otherwise lowest requesting channel
    always_comb begin
        grant = '0;
        taken = bus.init_we;
        wen   = bus.init_we;
        waddr = bus.init_addr;
        wdata = bus.init_data;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wreq[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
                wen      = 1'b1;
                waddr    = cur_addr[i];
                wdata    = cur_wdata[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wen) mem[to_idx(waddr)] <= wdata;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (complete[i])
                rdata[i*DATA_W +: DATA_W] = mem[to_idx(cur_addr[i])];
        end
    end

    assign bus.ch_rdata    = rdata;
    assign bus.ch_complete = complete;
    assign bus.busy        = busy;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder (two channels, default sizes).
// Expected completion cycle and read data are queued per channel at issue.
module tb_lc3_mem_responder;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t sbq [2][$];

    lc3_mem_responder_if #(.NUM_CH(2)) bus ();

    lc3_mem_responder #(.NUM_CH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (bus.ch_complete[c] === 1'b1) begin
                if (sbq[c].size() == 0) begin
                    chk($sformatf("ch%0d_spurious", c),
                        32'(bus.ch_complete[c]), 0);
                end else begin
                    e = sbq[c].pop_front();
                    chk($sformatf("ch%0d_cyc", c), cyc, e.cyc);
                    if (e.rd)
                        chk($sformatf("ch%0d_rdata", c),
                            32'(bus.ch_rdata[c*16 +: 16]), 32'(e.data));
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        bus.init_we   = 1'b1;
        bus.init_addr = a;
        bus.init_data = d;
        @(posedge clock);
        #1;
        bus.init_we   = 1'b0;
    endtask

    task automatic req(input int ch, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [3:0] lat,
                       input logic [15:0] exp_data, input int extra);
        exp_t e;
        bit   done;
        bus.ch_we[ch]              = we;
        bus.ch_addr[ch*16 +: 16]   = a;
        bus.ch_wdata[ch*16 +: 16]  = wd;
        bus.ch_lat[ch*4 +: 4]      = lat;
        bus.ch_en[ch]              = 1'b1;
        e.cyc  = cyc + ((lat == 0) ? 0 : int'(lat) + 1) + extra;
        e.rd   = !we;
        e.data = exp_data;
        sbq[ch].push_back(e);
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.ch_complete[ch]) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk($sformatf("ch%0d_timeout", ch), 0, 1);
        @(posedge clock);
        #1;
        bus.ch_en[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        bus.ch_en     = '0;
        bus.ch_we     = '0;
        bus.ch_addr   = '0;
        bus.ch_wdata  = '0;
        bus.ch_lat    = '0;
        bus.init_we   = 1'b0;
        bus.init_addr = '0;
        bus.init_data = '0;
        #12;
        chk("rst_complete", 32'(bus.ch_complete), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rdata", bus.ch_rdata, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;

        preload(16'h3000, 16'h1234);
        preload(16'h3005, 16'hBEEF);
        preload(16'h3010, 16'h0000);
        preload(16'h3020, 16'h7777);
        preload(16'h3040, 16'h2222);

        req(0, 0, 16'h3000, 16'h0, 4'd0, 16'h1234, 0);
        req(1, 0, 16'h3005, 16'h0, 4'd3, 16'hBEEF, 0);
        req(1, 0, 16'h3005, 16'h0, 4'd1, 16'hBEEF, 0);
        req(0, 0, 16'h3005, 16'h0, 4'd15, 16'hBEEF, 0);

        fork
            req(0, 1, 16'h3010, 16'hAAAA, 4'd2, 16'h0, 0);
            req(1, 1, 16'h3010, 16'h5555, 4'd2, 16'h0, 1);
        join
        req(0, 0, 16'h3010, 16'h0, 4'd0, 16'h5555, 0);

        bus.ch_we[1]          = 1'b1;
        bus.ch_addr[31:16]    = 16'h3020;
        bus.ch_wdata[31:16]   = 16'h9999;
        bus.ch_lat[7:4]       = 4'd4;
        bus.ch_en[1]          = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_busy_wait", 32'(bus.busy[1]), 1);
        bus.ch_en[1] = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_busy_idle", 32'(bus.busy[1]), 0);
        repeat (6) @(posedge clock);
        #1;
        req(0, 0, 16'h3020, 16'h0, 4'd0, 16'h7777, 0);

        req(1, 0, 16'h4000, 16'h0, 4'd0, 16'h1234, 0);

        fork
            req(0, 1, 16'h3040, 16'h1111, 4'd0, 16'h0, 0);
            req(1, 0, 16'h3040, 16'h0, 4'd0, 16'h2222, 0);
        join
        req(1, 0, 16'h3040, 16'h0, 4'd2, 16'h1111, 0);

        fork
            preload(16'h3050, 16'hCCCC);
            req(0, 1, 16'h3050, 16'hDDDD, 4'd0, 16'h0, 1);
        join
        req(0, 0, 16'h3050, 16'h0, 4'd0, 16'hDDDD, 0);

        bus.ch_we[0]        = 1'b0;
        bus.ch_addr[15:0]   = 16'h3000;
        bus.ch_lat[3:0]     = 4'd5;
        bus.ch_en[0]        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wait_busy", 32'(bus.busy[0]), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_busy", 32'(bus.busy[0]), 0);
        chk("rst_async_complete", 32'(bus.ch_complete[0]), 0);
        bus.ch_en[0] = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock);
        #1;
        req(0, 0, 16'h3000, 16'h0, 4'd5, 16'h1234, 0);

        repeat (4) @(posedge clock);
        #1;
        for (int c = 0; c < 2; c++)
            chk($sformatf("ch%0d_sb_empty", c), sbq[c].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
